// File: rtl/btn_scheduler.sv
// btn_scheduler: shared push-button front end.
//   - Divides clk down to a sample tick.
//   - Debounces each button on a 3-sample history; 011 counts as one press.
//   - Latches presses as pending requests, with sticky overflow flags.
//   - Round-robin arbitrates pending requests onto a valid/ready command port.
// Optional feature: define BTN_SCHED_REPEAT_EN to build per-button auto-repeat
// (a synthetic press every REPEAT_TICKS ticks while a button stays held).

// Per-button debounce lane: sample history, press detect, optional auto-repeat.
module btn_lane #(
  parameter int unsigned REPEAT_TICKS = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic btn_i,
  output logic press_o
);
  logic [2:0] hist_q;
  logic [2:0] hist_d;
  logic       edge_press;

  assign hist_d     = {hist_q[1:0], btn_i};
  assign edge_press = tick_i && (hist_d == 3'b011);

  // shift one sample into the history on every tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        hist_q <= '0;
    else if (tick_i) hist_q <= hist_d;
  end

`ifdef BTN_SCHED_REPEAT_EN
  localparam int unsigned RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

  logic [RW-1:0] rpt_q;
  logic          held;
  logic          rpt_fire;

  assign held     = tick_i && (hist_d == 3'b111);
  assign rpt_fire = held && (rpt_q == RW'(REPEAT_TICKS - 1));

  // hold-time counter: restarts on a real press or once the button reads low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      rpt_q <= '0;
    else if (edge_press || !hist_q[0]) rpt_q <= '0;
    else if (held)                 rpt_q <= rpt_fire ? '0 : rpt_q + 1'b1;
  end

  assign press_o = edge_press | rpt_fire;
`else
  assign press_o = edge_press;
`endif

endmodule

module btn_scheduler #(
  parameter int unsigned NUM_BTN      = 4,
  parameter int unsigned ID_W         = 2,
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned REPEAT_TICKS = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic               cmd_ready,
  input  logic               ovf_clr,
  output logic               cmd_valid,
  output logic [ID_W-1:0]    cmd_id,
  output logic [NUM_BTN-1:0] pending,
  output logic [NUM_BTN-1:0] ovf_flags,
  output logic               sample_tick
);
  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  typedef enum logic {IDLE, OFFER} state_e;

  logic [CW-1:0]      cnt_q;
  logic               tick_q;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [NUM_BTN-1:0] ovf_q, ovf_d;
  logic [NUM_BTN-1:0] hs_mask;
  logic               hs;
  state_e             state_q;
  logic               cmd_valid_q;
  logic [ID_W-1:0]    cmd_id_q;
  logic [ID_W-1:0]    last_q;
  logic               pick_vld;
  logic [ID_W-1:0]    pick_id;

  // free-running divider; tick is registered so it lands the cycle after the wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == CNT_LAST);
      cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
    btn_lane #(.REPEAT_TICKS(REPEAT_TICKS)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .tick_i (tick_q),
      .btn_i  (btn_in[g]),
      .press_o(press[g])
    );
  end

  assign hs = (state_q == OFFER) && cmd_ready;

  // one-hot of the request being retired by this cycle's handshake
  always_comb begin
    hs_mask = '0;
    for (int i = 0; i < NUM_BTN; i++)
      hs_mask[i] = hs && (cmd_id_q == ID_W'(i));
  end

  // a press on a bit that stays pending is lost and flagged; a press that
  // coincides with its own handshake simply re-arms the bit
  always_comb begin
    pending_d = (pending_q & ~hs_mask) | press;
    ovf_d     = (ovf_clr ? '0 : ovf_q) | (press & pending_q & ~hs_mask);
  end

  // pending request and overflow registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  // round-robin pick: scan farthest-first so the nearest set bit after
  // last_q is the one that sticks
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = NUM_BTN; k >= 1; k--) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (pending_q[i] && ((int'(last_q) + k == i) || (int'(last_q) + k == i + NUM_BTN))) begin
          pick_vld = 1'b1;
          pick_id  = ID_W'(i);
        end
      end
    end
  end

  // offer FSM: register a pick, hold it until accepted, then idle one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= '0;
      last_q      <= ID_W'(NUM_BTN - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            cmd_id_q    <= pick_id;
            cmd_valid_q <= 1'b1;
            state_q     <= OFFER;
          end
        end
        OFFER: begin
          if (cmd_ready) begin
            last_q      <= cmd_id_q;
            cmd_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          cmd_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_id      = cmd_id_q;
  assign pending     = pending_q;
  assign ovf_flags   = ovf_q;
  assign sample_tick = tick_q;

endmodule
